// File: rtl/pix2byte_sync_fifo.sv
// Single-clock FIFO between the pixel and byte domains of the same clock.
// It offers a standard registered-read mode and a first-word-fall-through
// mode, occupancy flags, and sticky overflow/underflow error flags.
// In FWFT mode the presented word is a prefetched copy of the head entry,
// so Count still counts it as stored until it is popped.
module pix2byte_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int AE_THRESH  = 8,
    parameter int AF_THRESH  = 504,
    parameter int FWFT_EN    = 0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Empty,
    output logic                  Full,
    output logic                  AlmostEmpty,
    output logic                  AlmostFull,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0]         AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]         ONE_C   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2-1:0] rdNext;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ae_q, ae_d;
    logic                  af_q, af_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  valid_q, valid_d;
    logic                  wrAccept;
    logic                  rdAccept;

    // A flush takes priority and suppresses both requests on its edge;
    // otherwise the registered Full/Empty gate the requests.
    assign wrAccept = WrEn & ~full_q & ~Flush;
    assign rdAccept = RdEn & ~empty_q & ~Flush;
    assign rdNext   = rdPtr_q + PTR_ONE;

    // Next-state logic for pointers, occupancy, output word and flags.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        valid_d = valid_q;

        if (Flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (WrEn & full_q);
            unf_d = unf_q | (RdEn & empty_q);

            if (wrAccept) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (rdAccept) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end

            if (wrAccept && !rdAccept) begin
                count_d = count_q + ONE_C;
            end else if (!wrAccept && rdAccept) begin
                count_d = count_q - ONE_C;
            end

            if (FWFT_EN == 0) begin
                if (rdAccept) begin
                    q_d = mem_q[rdPtr_q];
                end
            end else begin
                if (rdAccept) begin
                    if (count_q > ONE_C) begin
                        q_d     = mem_q[rdNext];
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (!valid_q && (count_q != '0)) begin
                    q_d     = mem_q[rdPtr_q];
                    valid_d = 1'b1;
                end
            end
        end

        empty_d = (FWFT_EN != 0) ? ~valid_d : (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        ae_d    = (count_d <= AE_C);
        af_d    = (count_d >= AF_C);
    end

    // Storage array; contents survive reset and flush since only the
    // pointers and count decide what is readable.
    always_ff @(posedge Clock) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= Data;
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            q_q     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            q_q     <= q_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            valid_q <= valid_d;
        end
    end

    assign Q           = q_q;
    assign Empty       = empty_q;
    assign Full        = full_q;
    assign AlmostEmpty = ae_q;
    assign AlmostFull  = af_q;
    assign Count       = count_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;

endmodule

// File: tb/tb_pix2byte_sync_fifo.sv
// Bench for pix2byte_sync_fifo: a default-parameter standard-mode FIFO and
// a small four-deep FWFT FIFO share one set of inputs; each phase checks
// only the instance it targets, then a random stream on the standard FIFO
// is compared against a queue model.
module tb_pix2byte_sync_fifo;

    logic       clock  = 1'b0;
    logic       resetN = 1'b1;
    logic [7:0] tData  = '0;
    logic       tWrEn  = 1'b0;
    logic       tRdEn  = 1'b0;
    logic       tFlush = 1'b0;

    logic [7:0] q0;
    logic       empty0, full0, ae0, af0, ovf0, unf0;
    logic [9:0] count0;

    logic [7:0] q1;
    logic       empty1, full1, ae1, af1, ovf1, unf1;
    logic [2:0] count1;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [7:0] mq [$];
    logic [7:0] mQ;
    logic       mOvf, mUnf, mEmpty, mFull;
    logic       wr, rd, fl;
    logic [7:0] d;
    int         sz;

    pix2byte_sync_fifo dut0 (
        .Clock(clock), .Reset_n(resetN), .Data(tData), .WrEn(tWrEn),
        .RdEn(tRdEn), .Flush(tFlush), .Q(q0), .Empty(empty0), .Full(full0),
        .AlmostEmpty(ae0), .AlmostFull(af0), .Count(count0),
        .Overflow(ovf0), .Underflow(unf0)
    );

    pix2byte_sync_fifo #(
        .DATA_WIDTH(8), .DEPTH_LOG2(2), .AE_THRESH(1), .AF_THRESH(3), .FWFT_EN(1)
    ) dut1 (
        .Clock(clock), .Reset_n(resetN), .Data(tData), .WrEn(tWrEn),
        .RdEn(tRdEn), .Flush(tFlush), .Q(q1), .Empty(empty1), .Full(full1),
        .AlmostEmpty(ae1), .AlmostFull(af1), .Count(count1),
        .Overflow(ovf1), .Underflow(unf1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic f, input logic [7:0] dat);
        tWrEn  = w;
        tRdEn  = r;
        tFlush = f;
        tData  = dat;
        @(posedge clock);
        #1;
    endtask

    task automatic holdReset();
        resetN = 1'b0;
        tWrEn  = 1'b0;
        tRdEn  = 1'b0;
        tFlush = 1'b0;
        #2;
    endtask

    task automatic releaseReset();
        @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        holdReset();
        releaseReset();

        // Reset state and ordered write/read of 0x00..0x07
        checkOutput("rstEmpty", 32'(empty0), 1);
        checkOutput("rstCount", 32'(count0), 0);
        checkOutput("rstQ", 32'(q0), 0);
        checkOutput("rstFlags", 32'({full0, ae0, af0, ovf0, unf0}), 32'b01000);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
        checkOutput("wr8Count", 32'(count0), 8);
        checkOutput("wr8Empty", 32'(empty0), 0);
        checkOutput("wr8Ae", 32'(ae0), 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("rdQ", 32'(q0), i);
        end
        checkOutput("rd8Empty", 32'(empty0), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("emptyRdUnf", 32'(unf0), 1);
        checkOutput("emptyRdQHold", 32'(q0), 7);

        // Asynchronous reset takes effect before any clock edge
        holdReset();
        checkOutput("asyncQ", 32'(q0), 0);
        checkOutput("asyncUnf", 32'(unf0), 0);
        checkOutput("asyncEmpty", 32'(empty0), 1);
        releaseReset();

        // Fill to 512 with threshold crossings, then overflow
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 7)   checkOutput("ae8", 32'(ae0), 1);
            if (i == 8)   checkOutput("ae9", 32'(ae0), 0);
            if (i == 502) checkOutput("af503", 32'(af0), 0);
            if (i == 503) checkOutput("af504", 32'(af0), 1);
            if (i == 510) checkOutput("full511", 32'(full0), 0);
        end
        checkOutput("full512", 32'(full0), 1);
        checkOutput("count512", 32'(count0), 512);
        checkOutput("ovfBefore", 32'(ovf0), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
        checkOutput("ovfCount", 32'(count0), 512);
        checkOutput("ovfSet", 32'(ovf0), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
        checkOutput("fullBothCount", 32'(count0), 511);
        checkOutput("fullBothFull", 32'(full0), 0);
        checkOutput("fullBothQ", 32'(q0), 0);
        for (int i = 1; i < 512; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("drainQ", 32'(q0), i & 255);
        end
        checkOutput("drainEmpty", 32'(empty0), 1);
        checkOutput("drainCount", 32'(count0), 0);
        checkOutput("ovfSticky", 32'(ovf0), 1);
        checkOutput("unfBefore", 32'(unf0), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        checkOutput("emptyBothCount", 32'(count0), 1);
        checkOutput("emptyBothUnf", 32'(unf0), 1);
        checkOutput("emptyBothEmpty", 32'(empty0), 0);

        // Flush discards data, ignores requests, keeps Q and sticky flags
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h02);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
        checkOutput("preFlushCount", 32'(count0), 4);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hC3);
        checkOutput("flushCount", 32'(count0), 0);
        checkOutput("flushFlags", 32'({empty0, full0, ae0, af0, ovf0, unf0}), 32'b101011);
        checkOutput("flushQ", 32'(q0), 'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("postFlushQ", 32'(q0), 'h3C);
        checkOutput("postFlushEmpty", 32'(empty0), 1);

        // FWFT instance: fall-through latency, pop, wrap, full, flush
        holdReset();
        releaseReset();
        checkOutput("fRstEmpty", 32'(empty1), 1);
        checkOutput("fRstQ", 32'(q1), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
        checkOutput("fWrEmpty", 32'(empty1), 1);
        checkOutput("fWrCount", 32'(count1), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("fFallEmpty", 32'(empty1), 0);
        checkOutput("fFallQ", 32'(q1), 'hA5);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fPopEmpty", 32'(empty1), 1);
        checkOutput("fPopCount", 32'(count1), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h11);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h22);
        checkOutput("fHeadQ", 32'(q1), 'h11);
        checkOutput("fHeadEmpty", 32'(empty1), 0);
        checkOutput("fAe2", 32'(ae1), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h33);
        checkOutput("fAf3", 32'(af1), 1);
        checkOutput("fFull3", 32'(full1), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h44);
        checkOutput("fFull4", 32'(full1), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h55);
        checkOutput("fOvf", 32'(ovf1), 1);
        checkOutput("fOvfCount", 32'(count1), 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fPop1Q", 32'(q1), 'h22);
        checkOutput("fPop1Full", 32'(full1), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fPop2Q", 32'(q1), 'h33);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fPop3Q", 32'(q1), 'h44);
        checkOutput("fPop3Count", 32'(count1), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fPop4Empty", 32'(empty1), 1);
        checkOutput("fUnfBefore", 32'(unf1), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fUnf", 32'(unf1), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h66);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("fQ66", 32'(q1), 'h66);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
        checkOutput("fFlushEmpty", 32'(empty1), 1);
        checkOutput("fFlushCount", 32'(count1), 0);
        checkOutput("fFlushQ", 32'(q1), 'h66);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("fQ77", 32'(q1), 'h77);
        checkOutput("fQ77Empty", 32'(empty1), 0);

        // Random stream on the standard FIFO against a queue model
        holdReset();
        releaseReset();
        mq.delete();
        mQ   = '0;
        mOvf = 1'b0;
        mUnf = 1'b0;
        for (int step = 0; step < 1500; step++) begin
            if (step == 1200) begin
                holdReset();
                releaseReset();
                mq.delete();
                mQ   = '0;
                mOvf = 1'b0;
                mUnf = 1'b0;
            end else begin
                wr = ($urandom_range(0, 99) < 55);
                rd = ($urandom_range(0, 99) < 45);
                fl = (step == 700);
                d  = 8'($urandom_range(0, 255));
                if (fl) begin
                    mq.delete();
                end else begin
                    mEmpty = (mq.size() == 0);
                    mFull  = (mq.size() == 512);
                    if (wr && mFull) mOvf = 1'b1;
                    if (rd && mEmpty) mUnf = 1'b1;
                    if (rd && !mEmpty) mQ = mq.pop_front();
                    if (wr && !mFull) mq.push_back(d);
                end
                applyStimulus(wr, rd, fl, d);
            end
            sz = mq.size();
            checkOutput("rndCount", 32'(count0), sz);
            checkOutput("rndQ", 32'(q0), 32'(mQ));
            checkOutput("rndFlags", 32'({empty0, full0, ae0, af0, ovf0, unf0}),
                        32'({sz == 0, sz == 512, sz <= 8, sz >= 504, mOvf, mUnf}));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
